seg_scan_controller: RTL
========================

Name: seg_scan_controller

Overview:
Time-multiplexes one shared binary-to-7-segment decoder across NUM_DIGITS common-cathode digits of the nap-timer display. Each digit gets a dwell slot and is scanned right to left, digit 0 first. Each slot starts with an inter-digit blanking gap to suppress ghosting. Sits between the timer/menu logic, which supplies packed BCD digits, and the external decoder, whose bNum/seg ports this block drives and consumes.

Parameters:
NUM_DIGITS, 4, number of scanned digits (2..8)
DWELL_CYCLES, 50000, clk cycles per digit slot including blanking (>= BLANK_CYCLES+1)
BLANK_CYCLES, 16, cycles at the start of each slot with all digit enables off (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
digits_in  in  4*NUM_DIGITS  packed digit values; digit i at [4i+3:4i]
load  in  1  single-cycle strobe; captures digits_in into shadow register
enable  in  1  scanning on when 1; display dark when 0
bnum  out  4  value presented to shared decoder
seg_in  in  7  decoder output for bnum (combinational, same cycle)
seg_out  out  7  registered segment drive to panel
digit_en  out  NUM_DIGITS  one-hot active-high digit select
frame_done  out  1  one-cycle pulse after last digit slot completes

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - shadow = 0, bnum = 0, seg_out = 0, digit_en = 0, frame_done = 0.
  - digit index = 0, dwell counter = 0, state IDLE.
- Shadow register: on load=1, shadow <= digits_in at the next edge. The new value takes effect from the next BLANK entry only, so no mid-slot glitch. If load occurs while the block is in IDLE, shadow updates immediately.
- FSM IDLE -> BLANK, when enable=1: index=0, counter=0.
- FSM BLANK:
  - digit_en = 0, seg_out = 0.
  - bnum = shadow[index], presented early so the decoder settles.
  - After BLANK_CYCLES cycles -> SHOW.
- FSM SHOW:
  - seg_out <= seg_in (registered, 1-cycle latency from bnum).
  - digit_en = one-hot(index), asserted from the first SHOW cycle.
  - When counter reaches DWELL_CYCLES-1: counter = 0 and index advances. Index wraps NUM_DIGITS-1 -> 0. At the wrap, frame_done pulses for exactly one cycle, coincident with the next BLANK's first cycle. Then -> BLANK.
- enable=0 in any state: next cycle -> IDLE with digit_en = 0, seg_out = 0, counter and index cleared. No partial slot resumes.
- Counter width: clog2(DWELL_CYCLES). No overflow past DWELL_CYCLES-1.
- Digit values 10..15 pass unchanged to bnum; the decoder yields blank (seg_in = 0), which is the accepted display for invalid BCD.
- load and slot boundary in the same cycle: the boundary samples the old shadow, and the new shadow applies from the following slot.
- rst_n asserted mid-slot: all outputs go to 0 immediately (asynchronous).

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: digits from NUM_DIGITS-1 downward whose shadow value is 0, up to but excluding the first nonzero digit, are suppressed. Their slot timing is unchanged, but digit_en stays 0 during SHOW. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Undefined: all digits shown.

Decomposition:
- Package seg_scan_pkg:
  - FSM state enum (IDLE, BLANK, SHOW).
  - SEG_BLANK = 7'b0.
  - function onehot(idx, n).
- One sub-module is natural: seg_dwell_timer, the parameterised counter that emits blank_done and slot_done.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=6, BLANK_CYCLES=2, seg_in driven by a reference decoder model):
1. Reset, load digits_in=16'h1234, enable=1 -> digit_en sequence 0001,0010,0100,1000; each asserted 4 cycles after 2 blank cycles; bnum 4,3,2,1; frame_done pulses every 24 cycles.
2. load 16'h5678 mid-slot of digit 1 -> digit 1 completes with 3; digit 2 shows 6 (new value).
3. enable dropped during SHOW of digit 2 -> next cycle digit_en=0, seg_out=0; re-enable -> scan restarts at digit 0 after 2 blank cycles.
4. Digit value 4'hB -> bnum=B, seg_out=0 while digit_en active.
5. With LEADING_ZERO_BLANK_EN: load 16'h0030 -> digits 3 and 2 suppressed (digit_en stays 0); digit 1 shows 3, digit 0 shows 0. Load 16'h0000 -> only digit 0 lit.
6. rst_n pulsed low mid-SHOW -> outputs 0 within the same cycle; after release, IDLE until enable is re-observed.

Source files
------------

// File: rtl/seg_scan_controller_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    // One-hot digit select; out-of-range index yields all zeros.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_DIGITS-1:0] sel;
        sel = '0;
        if (idx < n && idx < MAX_DIGITS) begin
            sel = MAX_DIGITS'(1) << idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Digit source / decoder / panel signals of the scan controller.
interface seg_scan_if
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
    logic                          load;
    logic                          enable;
    logic [DIGIT_W-1:0]            bnum;
    logic [SEG_W-1:0]              seg_in;
    logic [SEG_W-1:0]              seg_out;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic                          frame_done;

    // Timer/menu logic plus decoder side.
    modport master (
        output digits_in, load, enable, seg_in,
        input  bnum, seg_out, digit_en, frame_done
    );

    // Scan controller side.
    modport slave (
        input  digits_in, load, enable, seg_in,
        output bnum, seg_out, digit_en, frame_done
    );
endinterface

// File: rtl/seg_scan_controller_timer.sv
// Slot timer: counts cycles within a digit slot and flags the end of
// blanking and the end of the slot.
module seg_dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_done_c,
    output logic slot_done_c
);
    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Slot cycle counter; wraps at the end of each slot, held at 0 while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign blank_done_c = !clear && (cnt_q == BLANK_END);
    assign slot_done_c  = !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS
// common-cathode digits, scanning digit 0 first with a blanking gap at the
// start of every slot.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned SHAD_W  = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [SHAD_W-1:0]     shadow_q;
    logic [DIGIT_W-1:0]    bnum_q, bnum_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  frame_q, frame_d;
    logic                  sup_q, sup_d;

    logic                  timer_clear;
    logic                  blank_done_c;
    logic                  slot_done_c;
    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      entry_idx;
    logic [DIGIT_W-1:0]    entry_digit;
    logic                  entry_sup;
    logic [NUM_DIGITS-1:0] slot_en;

    seg_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (timer_clear),
        .blank_done_c (blank_done_c),
        .slot_done_c  (slot_done_c)
    );

    assign timer_clear = (state_q == IDLE) || !bus.enable;

    // Slot index that the next BLANK entry will use, and its digit value.
    assign next_idx    = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
    assign entry_idx   = (state_q == IDLE) ? '0 : next_idx;
    assign entry_digit = shadow_q[{entry_idx, 2'b00} +: DIGIT_W];
    assign slot_en     = NUM_DIGITS'(onehot(32'(index_q), NUM_DIGITS));

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;

    // Mark digits that are zero all the way down from the top digit; digit 0 is always shown.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (shadow_q[DIGIT_W*i +: DIGIT_W] == '0);
            lead_zero[i] = zero_run;
        end
        lead_zero[0] = 1'b0;
    end

    assign entry_sup = lead_zero[entry_idx];
`else
    assign entry_sup = 1'b0;
`endif

    // Shadow capture; the scan only samples it at BLANK entry, so loads never glitch a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (bus.load) begin
            shadow_q <= bus.digits_in;
        end
    end

    // State and registered output bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            bnum_q  <= '0;
            seg_q   <= SEG_BLANK;
            en_q    <= '0;
            frame_q <= 1'b0;
            sup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            bnum_q  <= bnum_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            frame_q <= frame_d;
            sup_q   <= sup_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the upcoming state.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        bnum_d  = bnum_q;
        sup_d   = sup_q;
        en_d    = '0;
        seg_d   = SEG_BLANK;
        frame_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = BLANK;
                    index_d = '0;
                    bnum_d  = entry_digit;
                    sup_d   = entry_sup;
                end
            end
            BLANK: begin
                if (blank_done_c) begin
                    state_d = SHOW;
                    en_d    = sup_q ? '0 : slot_en;
                    seg_d   = bus.seg_in;
                end
            end
            SHOW: begin
                if (slot_done_c) begin
                    state_d = BLANK;
                    index_d = next_idx;
                    bnum_d  = entry_digit;
                    sup_d   = entry_sup;
                    frame_d = (index_q == LAST_IDX);
                end else begin
                    en_d    = sup_q ? '0 : slot_en;
                    seg_d   = bus.seg_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping enable goes dark at once and forgets the partial frame.
        if (!bus.enable) begin
            state_d = IDLE;
            index_d = '0;
            sup_d   = 1'b0;
            en_d    = '0;
            seg_d   = SEG_BLANK;
            frame_d = 1'b0;
        end
    end

    assign bus.bnum       = bnum_q;
    assign bus.seg_out    = seg_q;
    assign bus.digit_en   = en_q;
    assign bus.frame_done = frame_q;

endmodule
